// File: rtl/bram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bram_req_ctrl
// Purpose  : Requester-side controller for a dual-port block RAM with write
//            port A, read port B and a one-cycle registered read. It converts
//            a 32-bit valid/ready load/store stream into line-wide BRAM
//            accesses. It places the addressed word within the line, applies
//            byte strobes, and returns one response per request.
// Ports    : clk, rst                        clock, async active-high reset
//            i_req_*  / o_req_ready          request channel (valid/ready)
//            o_resp_* / i_resp_ready         response channel (valid/ready)
//            o_bram_ena/wea/addra/dia        BRAM write port A
//            o_bram_enb/addrb, i_bram_dob    BRAM read port B
// Revision : 1.0 - initial release
// ============================================================================
module bram_req_ctrl #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 128,
  parameter int XLEN  = 32,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int OFFW  = $clog2(WIDTH/8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [31:0]          i_req_addr,
  input  logic [XLEN-1:0]      i_req_wdata,
  input  logic [XLEN/8-1:0]    i_req_wstrb,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [XLEN-1:0]      o_resp_rdata,
  output logic                 o_resp_err,
  output logic                 o_bram_ena,
  output logic [WIDTH/8-1:0]   o_bram_wea,
  output logic [ADDRW-1:0]     o_bram_addra,
  output logic [WIDTH-1:0]     o_bram_dia,
  output logic                 o_bram_enb,
  output logic [ADDRW-1:0]     o_bram_addrb,
  input  logic [WIDTH-1:0]     i_bram_dob
);

  localparam int          c_LANES = WIDTH / XLEN;
  localparam int          c_STRBW = XLEN / 8;
  localparam int          c_LANEW = OFFW - 2;
  // One past the last valid byte address; 33 bits so the compare never wraps.
  localparam logic [32:0] c_LIMIT = 33'(DEPTH * (WIDTH / 8));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [XLEN-1:0]      r_rdata;
  logic                 r_err;
  logic [c_LANEW-1:0]   r_lane;

  logic                 w_accept;
  logic                 w_oor;
  logic                 w_do_load;
  logic                 w_do_store;
  logic [ADDRW-1:0]     w_line;
  logic [c_LANEW-1:0]   w_lane;
  logic [XLEN-1:0]      w_rd_word;
  logic [WIDTH/8-1:0]   w_wea;

  assign w_line = i_req_addr[OFFW+ADDRW-1:OFFW];
  assign w_lane = i_req_addr[OFFW-1:2];
  assign w_oor  = ({1'b0, i_req_addr} >= c_LIMIT);

  // A new request may enter in the same cycle the current response retires,
  // which gives a bubble-free back-to-back stream.
  assign o_req_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && i_resp_ready);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_do_load   = w_accept && !i_req_we && !w_oor;
  assign w_do_store  = w_accept &&  i_req_we && !w_oor;

  // BRAM ports are driven only in the accept cycle so the write lands on the
  // accept edge and a following load sees it.
  assign o_bram_enb   = w_do_load;
  assign o_bram_addrb = w_line;
  assign o_bram_ena   = w_do_store;
  assign o_bram_addra = w_line;
  assign o_bram_dia   = {c_LANES{i_req_wdata}};
  assign o_bram_wea   = w_wea;

  always_comb begin
    w_wea = '0;
    for (int i = 0; i < c_LANES; i++) begin
      if (w_do_store && (w_lane == c_LANEW'(i))) begin
        w_wea[i*c_STRBW +: c_STRBW] = i_req_wstrb;
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < c_LANES; i++) begin
      if (r_lane == c_LANEW'(i)) begin
        w_rd_word = i_bram_dob[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_RD:    w_state_nxt = S_RESP;
      S_RESP:  if (i_resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_accept) begin
      w_state_nxt = w_do_load ? S_RD : S_RESP;
    end
  end

  // Response payload: cleared on every accept (stores/errors return zero),
  // loaded from the BRAM word in the RD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_lane  <= '0;
    end else if (w_accept) begin
      r_rdata <= '0;
      r_err   <= w_oor;
      r_lane  <= w_lane;
    end else if (r_state == S_RD) begin
      r_rdata <= w_rd_word;
      r_err   <= 1'b0;
    end
  end

  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

endmodule
`default_nettype wire
